// File: rtl/song_addr_seq.sv
// -----------------------------------------------------------------------------
// song_addr_seq
//   Note-ROM address sequencer. START loads the first address of song SEL and
//   plays it, advancing one address per TICK until the song's last address.
//   There it either wraps to the song's start (LOOP=1) or stops with a one-cycle
//   DONE pulse (LOOP=0).
//
// Ports
//   CLK        single clock, rising edge
//   RST        synchronous reset, active-high, overrides all other inputs
//   TICK       note-rate enable; the address only advances when high
//   START      one-cycle request to play song SEL (ignored if SEL >= N_SONGS)
//   STOP       one-cycle request to abort playback (beats START)
//   PAUSE      level; freezes the address while high
//   LOOP       level; repeat (1) or one-shot (0), sampled at song end
//   SEL        song index for START
//   ADDR       current note-ROM address (registered)
//   CUR_SEL    index of the song in play (registered)
//   BUSY       high in PLAY and PAUSED
//   DONE       one-cycle pulse when a one-shot song completes
//   DBG_STATE  FSM state for observation: 0 IDLE, 1 PLAY, 2 PAUSED, 3 FINISH
//
// Handshake: START and STOP are single-cycle strobes with no ready/backpressure.
// They act on the cycle they are sampled high. Nothing is queued, and a strobe
// held high for several cycles acts on every one of those cycles.
//
// Configuration macro: SEQ_AUTO_NEXT_EN. When it is defined, a one-shot end
// moves on to the next song (modulo N_SONGS) and stays in PLAY while pulsing
// DONE, instead of going to FINISH.
// -----------------------------------------------------------------------------
module song_addr_seq #(
  parameter int ADDR_W  = 10,
  parameter int N_SONGS = 4,
  parameter int SEL_W   = (N_SONGS > 1) ? $clog2(N_SONGS) : 1,
  parameter logic [N_SONGS*ADDR_W-1:0] SONG_START =
    {10'd501, 10'd336, 10'd139, 10'd0},
  parameter logic [N_SONGS*ADDR_W-1:0] SONG_END =
    {10'd700, 10'd500, 10'd335, 10'd138}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TICK,
  input  logic              START,
  input  logic              STOP,
  input  logic              PAUSE,
  input  logic              LOOP,
  input  logic [SEL_W-1:0]  SEL,
  output logic [ADDR_W-1:0] ADDR,
  output logic [SEL_W-1:0]  CUR_SEL,
  output logic              BUSY,
  output logic              DONE,
  output logic [1:0]        DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_PAUSED = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam int unsigned N_SONGS_U = N_SONGS;

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [SEL_W-1:0]   cur_sel_q;
  logic               done_q;

  logic               sel_valid;
  logic               at_end;

  function automatic logic [ADDR_W-1:0] start_of(input int k);
    return SONG_START[k*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] end_of(input int k);
    return SONG_END[k*ADDR_W +: ADDR_W];
  endfunction

  // SEL may be wider than needed, so a request for a song that does not exist
  // must be filtered out before it can index the tables.
  always_comb begin
    sel_valid = (32'(SEL) < N_SONGS_U);
    at_end    = (addr_q == end_of(int'(cur_sel_q)));
  end

`ifdef SEQ_AUTO_NEXT_EN
  logic [SEL_W-1:0] next_sel;

  always_comb begin
    next_sel = cur_sel_q + SEL_W'(1);
    if (cur_sel_q == SEL_W'(N_SONGS - 1)) next_sel = '0;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cur_sel_q <= '0;
      addr_q    <= start_of(0);
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (STOP) begin
        state_q <= S_IDLE;
        addr_q  <= start_of(int'(cur_sel_q));
      end else if (START && sel_valid) begin
        state_q   <= S_PLAY;
        cur_sel_q <= SEL;
        addr_q    <= start_of(int'(SEL));
      end else if (START) begin
        // A request for a song that does not exist freezes everything for this
        // cycle, so a stray strobe cannot nudge the playback position.
        state_q <= state_q;
      end else begin
        case (state_q)
          S_PLAY: begin
            if (!PAUSE && TICK && at_end) begin
              if (LOOP) begin
                addr_q <= start_of(int'(cur_sel_q));
              end else begin
`ifdef SEQ_AUTO_NEXT_EN
                cur_sel_q <= next_sel;
                addr_q    <= start_of(int'(next_sel));
                done_q    <= 1'b1;
`else
                // The address holds at the song's end while FINISH runs.
                state_q <= S_FINISH;
                done_q  <= 1'b1;
`endif
              end
            end else if (PAUSE) begin
              state_q <= S_PAUSED;
            end else if (TICK) begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
          // Leaving PAUSED takes one cycle. The first TICK after resuming
          // moves the address on.
          S_PAUSED: if (!PAUSE) state_q <= S_PLAY;
          S_FINISH: state_q <= S_IDLE;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ADDR      = addr_q;
  assign CUR_SEL   = cur_sel_q;
  assign DONE      = done_q;
  assign BUSY      = (state_q == S_PLAY) || (state_q == S_PAUSED);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_song_addr_seq.sv
// -----------------------------------------------------------------------------
// tb_song_addr_seq
//   Directed bench for song_addr_seq built with the default song tables
//   (song0 0..138, song1 139..335, song2 336..500, song3 501..700) and SEL_W=3,
//   so that out-of-range song indices can be driven.
// -----------------------------------------------------------------------------
module tb_song_addr_seq;

  localparam int ST_IDLE   = 0;
  localparam int ST_PLAY   = 1;
  localparam int ST_PAUSED = 2;
  localparam int ST_FINISH = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TICK = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       PAUSE = 1'b0;
  logic       LOOP = 1'b0;
  logic [2:0] SEL = 3'd0;
  logic [9:0] ADDR;
  logic [2:0] CUR_SEL;
  logic       BUSY;
  logic       DONE;
  logic [1:0] DBG_STATE;

  int vectors = 0;
  int miscompares = 0;
  int done_seen;
  logic [9:0] exp_q[$];

  song_addr_seq #(
    .ADDR_W (10),
    .N_SONGS(4),
    .SEL_W  (3)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .TICK     (TICK),
    .START    (START),
    .STOP     (STOP),
    .PAUSE    (PAUSE),
    .LOOP     (LOOP),
    .SEL      (SEL),
    .ADDR     (ADDR),
    .CUR_SEL  (CUR_SEL),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_start(input logic [2:0] sel);
    SEL = sel;
    START = 1'b1;
    cyc();
    START = 1'b0;
  endtask

  task automatic do_stop();
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
  endtask

  // Scoreboard step: queue the address this TICK should produce, clock it and
  // compare the address that comes out. Any DONE pulse seen is counted.
  task automatic tick_expect(input logic [9:0] nxt);
    exp_q.push_back(nxt);
    TICK = 1'b1;
    cyc();
    TICK = 1'b0;
    check("addr_seq", 32'(ADDR), 32'(exp_q.pop_front()));
    if (DONE) done_seen++;
  endtask

  initial begin
    // reset
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
    check("rst_addr", 32'(ADDR), 0);
    check("rst_sel", 32'(CUR_SEL), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_state", 32'(DBG_STATE), ST_IDLE);

    // Song 0, one-shot, TICK every cycle.
    LOOP = 1'b0;
    do_start(3'd0);
    check("s0_start_addr", 32'(ADDR), 0);
    check("s0_start_busy", 32'(BUSY), 1);
    done_seen = 0;
    for (int a = 1; a <= 138; a++) tick_expect(10'(a));
    check("s0_no_early_done", 32'(done_seen), 0);
    TICK = 1'b1;
    cyc();
`ifdef SEQ_AUTO_NEXT_EN
    check("s0_auto_done", 32'(DONE), 1);
    check("s0_auto_sel", 32'(CUR_SEL), 1);
    check("s0_auto_addr", 32'(ADDR), 139);
    check("s0_auto_busy", 32'(BUSY), 1);
    TICK = 1'b0;
    do_stop();
`else
    check("s0_end_state", 32'(DBG_STATE), ST_FINISH);
    check("s0_end_addr", 32'(ADDR), 138);
    check("s0_end_done", 32'(DONE), 1);
    check("s0_end_busy", 32'(BUSY), 0);
    cyc();
    check("s0_idle_state", 32'(DBG_STATE), ST_IDLE);
    check("s0_done_once", 32'(DONE), 0);
    for (int i = 0; i < 3; i++) cyc();
    TICK = 1'b0;
    check("s0_addr_held", 32'(ADDR), 138);
    check("s0_busy_idle", 32'(BUSY), 0);
`endif

    // Song 1 looping, then STOP.
    LOOP = 1'b1;
    do_start(3'd1);
    check("s1_start_addr", 32'(ADDR), 139);
    check("s1_cur_sel", 32'(CUR_SEL), 1);
    done_seen = 0;
    for (int a = 140; a <= 335; a++) tick_expect(10'(a));
    tick_expect(10'd139);
    tick_expect(10'd140);
    tick_expect(10'd141);
    check("s1_loop_no_done", 32'(done_seen), 0);
    do_stop();
    check("s1_stop_state", 32'(DBG_STATE), ST_IDLE);
    check("s1_stop_addr", 32'(ADDR), 139);
    check("s1_stop_busy", 32'(BUSY), 0);
    check("s1_stop_done", 32'(DONE), 0);

    // Pause at address 50 of song 0.
    LOOP = 1'b0;
    do_start(3'd0);
    for (int a = 1; a <= 50; a++) tick_expect(10'(a));
    PAUSE = 1'b1;
    for (int i = 0; i < 5; i++) tick_expect(10'd50);
    check("pause_state", 32'(DBG_STATE), ST_PAUSED);
    check("pause_busy", 32'(BUSY), 1);
    PAUSE = 1'b0;
    tick_expect(10'd50);
    check("resume_state", 32'(DBG_STATE), ST_PLAY);
    tick_expect(10'd51);
    tick_expect(10'd52);

    // START and STOP together: STOP wins.
    SEL = 3'd2;
    START = 1'b1;
    STOP = 1'b1;
    cyc();
    START = 1'b0;
    STOP = 1'b0;
    check("startstop_state", 32'(DBG_STATE), ST_IDLE);
    check("startstop_sel", 32'(CUR_SEL), 0);
    check("startstop_addr", 32'(ADDR), 0);

    // Out-of-range song indices are ignored.
    do_start(3'd1);
    tick_expect(10'd140);
    do_start(3'd7);
    check("sel7_addr", 32'(ADDR), 140);
    check("sel7_cur_sel", 32'(CUR_SEL), 1);
    check("sel7_state", 32'(DBG_STATE), ST_PLAY);
    do_start(3'd4);
    check("sel4_addr", 32'(ADDR), 140);
    check("sel4_cur_sel", 32'(CUR_SEL), 1);

    // Reset in the middle of song 1 at address 200.
    for (int a = 141; a <= 200; a++) tick_expect(10'(a));
    RST = 1'b1;
    TICK = 1'b1;
    cyc();
    RST = 1'b0;
    check("midrst_addr", 32'(ADDR), 0);
    check("midrst_sel", 32'(CUR_SEL), 0);
    check("midrst_state", 32'(DBG_STATE), ST_IDLE);
    check("midrst_busy", 32'(BUSY), 0);
    for (int i = 0; i < 4; i++) tick_expect(10'd0);
    check("midrst_still_idle", 32'(DBG_STATE), ST_IDLE);

`ifdef SEQ_AUTO_NEXT_EN
    // Song 1 one-shot moves on to song 2.
    LOOP = 1'b0;
    do_start(3'd1);
    for (int a = 140; a <= 335; a++) tick_expect(10'(a));
    TICK = 1'b1;
    cyc();
    TICK = 1'b0;
    check("auto_done", 32'(DONE), 1);
    check("auto_sel", 32'(CUR_SEL), 2);
    check("auto_addr", 32'(ADDR), 336);
    check("auto_state", 32'(DBG_STATE), ST_PLAY);
    cyc();
    check("auto_done_once", 32'(DONE), 0);
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
